// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the committed-store buffer and its forwarding CAM.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_REQ  = 2'd1,
    SB_WAIT = 2'd2
  } sb_state_t;

  localparam logic REQ_WRITE  = 1'b1;
  localparam logic REQ_MEMORY = 1'b1;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  opcode;
  } sb_entry_t;

  function automatic logic [9:0] make_tag(input logic [7:0] opcode);
    return {REQ_WRITE, REQ_MEMORY, opcode};
  endfunction

endpackage

// File: rtl/store_buffer_cam.sv
// Address CAM over the buffered stores; the youngest matching valid entry supplies forwarded data.
module store_buffer_cam
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t          i_entries [DEPTH],
  input  logic [DEPTH-1:0]   i_valid,
  input  logic [PTR_W-1:0]   i_head,
  input  logic [63:0]        i_lookup_addr,
  output logic               o_hit,
  output logic [63:0]        o_data
);

  logic [DEPTH-1:0] w_match;
  logic [PTR_W-1:0] w_idx;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign w_match[gi] = i_valid[gi] && (i_entries[gi].addr == i_lookup_addr);
    end
  endgenerate

  // Walk from oldest (head) to youngest; a later match overrides an earlier one.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PTR_W'(k);
      if (w_match[w_idx]) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO that drains in order to the D-cache and forwards pending store data to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [63:0]      push_addr,
  input  logic [63:0]      push_data,
  input  logic [7:0]       push_opcode,
  output logic             reqcyc,
  output logic [63:0]      req,
  output logic [63:0]      reqdata,
  output logic [9:0]       reqtag,
  input  logic             reqack,
  input  logic             writeack,
  input  logic [63:0]      lookup_addr,
  output logic             lookup_hit,
  output logic [63:0]      lookup_data,
  output logic             write_retired,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             drained
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t        r_mem [DEPTH];
  sb_state_t        r_state;
  sb_state_t        w_state_next;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_req;
  logic [63:0]      r_reqdata;
  logic [9:0]       r_reqtag;
  logic             r_write_retired;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic [DEPTH-1:0] w_valid;
  sb_entry_t        w_push_entry;

  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign push_ready   = !w_full;
  assign w_push       = push_valid && push_ready;
  assign w_push_entry = '{addr: push_addr, data: push_data, opcode: push_opcode};

  // An entry is live when its distance from head is below the occupancy count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [PTR_W-1:0] w_age;
      assign w_age       = PTR_W'(gi) - r_head;
      assign w_valid[gi] = (CNT_W'(w_age) < r_count);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= w_push_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      SB_IDLE: begin
        if (r_count != '0) begin
          w_state_next = SB_REQ;
          w_load       = 1'b1;
        end
      end
      SB_REQ: begin
        if (reqack) begin
          if (writeack) begin
            w_pop        = 1'b1;
            w_state_next = SB_IDLE;
          end else begin
            w_state_next = SB_WAIT;
          end
        end
      end
      SB_WAIT: begin
        if (writeack) begin
          w_pop        = 1'b1;
          w_state_next = SB_IDLE;
        end
      end
      default: w_state_next = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_req           <= '0;
      r_reqdata       <= '0;
      r_reqtag        <= '0;
      r_write_retired <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count         <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_write_retired <= w_pop;
      // Request fields persist after the pop until the next entry is issued.
      if (w_load) begin
        r_req     <= r_mem[r_head].addr;
        r_reqdata <= r_mem[r_head].data;
        r_reqtag  <= make_tag(r_mem[r_head].opcode);
      end
    end
  end

  store_buffer_cam #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_cam (
    .i_entries     (r_mem),
    .i_valid       (w_valid),
    .i_head        (r_head),
    .i_lookup_addr (lookup_addr),
    .o_hit         (lookup_hit),
    .o_data        (lookup_data)
  );

  assign reqcyc        = (r_state == SB_REQ);
  assign req           = r_req;
  assign reqdata       = r_reqdata;
  assign reqtag        = r_reqtag;
  assign write_retired = r_write_retired;
  assign count         = r_count;
  assign empty         = (r_count == '0);
  assign drained       = (r_count == '0) && (r_state == SB_IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: issue order, wrap, forwarding, ack corner cases and async reset.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [63:0] push_addr;
  logic [63:0] push_data;
  logic [7:0]  push_opcode;
  logic        reqcyc;
  logic [63:0] req;
  logic [63:0] reqdata;
  logic [9:0]  reqtag;
  logic        reqack;
  logic        writeack;
  logic [63:0] lookup_addr;
  logic        lookup_hit;
  logic [63:0] lookup_data;
  logic        write_retired;
  logic [2:0]  count;
  logic        empty;
  logic        drained;

  int n_pass  = 0;
  int n_total = 0;

  store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_addr     (push_addr),
    .push_data     (push_data),
    .push_opcode   (push_opcode),
    .reqcyc        (reqcyc),
    .req           (req),
    .reqdata       (reqdata),
    .reqtag        (reqtag),
    .reqack        (reqack),
    .writeack      (writeack),
    .lookup_addr   (lookup_addr),
    .lookup_hit    (lookup_hit),
    .lookup_data   (lookup_data),
    .write_retired (write_retired),
    .count         (count),
    .empty         (empty),
    .drained       (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [7:0] op);
    int n = 0;
    while (!push_ready && n < 50) begin
      step();
      n++;
    end
    check("push_ready_wait", push_ready, 1'b1);
    push_valid  = 1'b1;
    push_addr   = a;
    push_data   = d;
    push_opcode = op;
    step();
    push_valid  = 1'b0;
    $display("push addr=0x%0h data=0x%0h op=0x%0h count=%0d", a, d, op, count);
  endtask

  task automatic wait_req(input logic [63:0] exp_addr, input logic [63:0] exp_data);
    int n = 0;
    while (!reqcyc && n < 20) begin
      step();
      n++;
    end
    check("reqcyc_wait", reqcyc, 1'b1);
    check("req_addr", req, exp_addr);
    check("req_data", reqdata, exp_data);
  endtask

  task automatic serve(input logic [63:0] exp_addr, input logic [63:0] exp_data);
    wait_req(exp_addr, exp_data);
    reqack = 1'b1;
    step();
    reqack = 1'b0;
    check("reqcyc_after_ack", reqcyc, 1'b0);
    writeack = 1'b1;
    step();
    writeack = 1'b0;
    check("write_retired_pulse", write_retired, 1'b1);
    $display("drain addr=0x%0h data=0x%0h count=%0d", req, reqdata, count);
  endtask

  initial begin
    reset       = 1'b0;
    push_valid  = 1'b0;
    push_addr   = '0;
    push_data   = '0;
    push_opcode = '0;
    reqack      = 1'b0;
    writeack    = 1'b0;
    lookup_addr = '0;
    step();
    step();
    check("rst_reqcyc", reqcyc, 1'b0);
    check("rst_req", req, 64'h0);
    check("rst_reqtag", reqtag, 10'h0);
    check("rst_count", count, 3'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_drained", drained, 1'b1);
    check("rst_push_ready", push_ready, 1'b1);
    check("rst_write_retired", write_retired, 1'b0);
    check("rst_lookup_hit", lookup_hit, 1'b0);
    check("rst_lookup_data", lookup_data, 64'h0);
    reset = 1'b1;
    step();

    // Single store: reqcyc two cycles after acceptance.
    lookup_addr = 64'h1000;
    push_valid  = 1'b1;
    push_addr   = 64'h1000;
    push_data   = 64'hDEAD_BEEF;
    push_opcode = 8'h89;
    step();
    push_valid  = 1'b0;
    check("single_n1_reqcyc", reqcyc, 1'b0);
    check("single_n1_count", count, 3'd1);
    check("single_fwd_hit", lookup_hit, 1'b1);
    check("single_fwd_data", lookup_data, 64'hDEAD_BEEF);
    step();
    check("single_n2_reqcyc", reqcyc, 1'b1);
    check("single_req", req, 64'h1000);
    check("single_reqdata", reqdata, 64'hDEAD_BEEF);
    check("single_reqtag", reqtag, 10'h389);
    check("single_drained_busy", drained, 1'b0);
    reqack = 1'b1;
    step();
    reqack = 1'b0;
    check("single_wait_reqcyc", reqcyc, 1'b0);
    check("single_wait_fwd", lookup_hit, 1'b1);
    check("single_wait_retired", write_retired, 1'b0);
    writeack = 1'b1;
    step();
    writeack = 1'b0;
    check("single_retired", write_retired, 1'b1);
    check("single_drained", drained, 1'b1);
    check("single_req_held", req, 64'h1000);
    step();
    check("single_retired_once", write_retired, 1'b0);
    check("single_reqcyc_idle", reqcyc, 1'b0);
    $display("single store done count=%0d drained=%0d", count, drained);

    // Forwarding: youngest match wins.
    push(64'h2000, 64'h11, 8'h01);
    push(64'h2000, 64'h22, 8'h02);
    lookup_addr = 64'h2000;
    #1;
    check("fwd_hit", lookup_hit, 1'b1);
    check("fwd_youngest", lookup_data, 64'h22);
    lookup_addr = 64'h2008;
    #1;
    check("fwd_miss_hit", lookup_hit, 1'b0);
    check("fwd_miss_data", lookup_data, 64'h0);
    lookup_addr = 64'h2000;
    serve(64'h2000, 64'h11);
    check("fwd_after_one_pop", lookup_data, 64'h22);
    serve(64'h2000, 64'h22);
    check("fwd_after_pop_hit", lookup_hit, 1'b0);
    check("fwd_after_pop_count", count, 3'd0);

    // Fill and wrap with cache stalled; head starts at 3.
    for (int i = 0; i < 4; i++) push(64'h3000 + 64'(i * 8), 64'hA0 + 64'(i), 8'h10);
    check("fill_ready_low", push_ready, 1'b0);
    check("fill_count", count, 3'd4);
    serve(64'h3000, 64'hA0);
    push(64'h3020, 64'hA4, 8'h10);
    check("refill_ready_low", push_ready, 1'b0);
    serve(64'h3008, 64'hA1);
    push(64'h3028, 64'hA5, 8'h10);
    for (int i = 2; i < 6; i++) serve(64'h3000 + 64'(i * 8), 64'hA0 + 64'(i));
    check("wrap_drained_count", count, 3'd0);
    step();
    check("wrap_drained", drained, 1'b1);

    // Same-cycle reqack + writeack, then push with pop in one cycle at count 2.
    push(64'h4000, 64'h40, 8'h20);
    push(64'h4008, 64'h48, 8'h21);
    wait_req(64'h4000, 64'h40);
    check("same_count_before", count, 3'd2);
    reqack   = 1'b1;
    writeack = 1'b1;
    step();
    reqack   = 1'b0;
    writeack = 1'b0;
    check("same_count_after", count, 3'd1);
    check("same_retired", write_retired, 1'b1);
    check("same_reqcyc_idle", reqcyc, 1'b0);
    step();
    check("same_single_pop", count, 3'd1);
    check("same_retired_end", write_retired, 1'b0);
    wait_req(64'h4008, 64'h48);
    push(64'h5000, 64'h50, 8'h22);
    reqack = 1'b1;
    step();
    reqack = 1'b0;
    check("pp_count_before", count, 3'd2);
    writeack    = 1'b1;
    push_valid  = 1'b1;
    push_addr   = 64'h5008;
    push_data   = 64'h58;
    push_opcode = 8'h23;
    step();
    writeack   = 1'b0;
    push_valid = 1'b0;
    check("pp_count_kept", count, 3'd2);
    check("pp_retired", write_retired, 1'b1);
    serve(64'h5000, 64'h50);
    check("pp_tag", reqtag, 10'h322);
    serve(64'h5008, 64'h58);
    check("pp_count_end", count, 3'd0);

    // Async reset while waiting on writeack with 3 entries.
    push(64'h6000, 64'h60, 8'h30);
    push(64'h6008, 64'h68, 8'h31);
    push(64'h6010, 64'h70, 8'h32);
    wait_req(64'h6000, 64'h60);
    reqack = 1'b1;
    step();
    reqack = 1'b0;
    check("ar_count_before", count, 3'd3);
    check("ar_drained_before", drained, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("ar_reqcyc", reqcyc, 1'b0);
    check("ar_count", count, 3'd0);
    check("ar_drained", drained, 1'b1);
    check("ar_req", req, 64'h0);
    lookup_addr = 64'h6000;
    #1;
    check("ar_lookup", lookup_hit, 1'b0);
    step();
    reset    = 1'b1;
    writeack = 1'b1;
    step();
    writeack = 1'b0;
    check("ar_late_ack_count", count, 3'd0);
    check("ar_late_ack_retired", write_retired, 1'b0);
    check("ar_late_ack_drained", drained, 1'b1);
    $display("async reset done count=%0d drained=%0d", count, drained);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Committed-store buffer between the write-back stage and the data-cache core port. Write-back pushes each retiring memory store (address, 64-bit data, opcode) in one cycle instead of stalling for the full cache round-trip. The buffer drains entries in order to the D-cache over the reqcyc/reqack/writeack handshake. Younger loads can look up pending stores to forward data.

## Interface
- DEPTH, 4: number of store entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH)+1: width of `count`.

Ports:
- clk  in  1  core clock.
- reset  in  1  one clock; reset is asynchronous and active-low.
- push_valid  in  1  write-back presents a committed store.
- push_ready  out  1  buffer can accept (`!full`, registered state only).
- push_addr  in  64  store byte address; 8-byte aligned.
- push_data  in  64  store data.
- push_opcode  in  8  primary opcode, carried into reqtag.
- reqcyc  out  1  D-cache request valid.
- req  out  64  request address.
- reqdata  out  64  request write data.
- reqtag  out  10  {REQ_WRITE, REQ_MEMORY, opcode}.
- reqack  in  1  cache accepted the request.
- writeack  in  1  cache completed the write.
- lookup_addr  in  64  load address to check.
- lookup_hit  out  1  some valid entry has the equal address.
- lookup_data  out  64  data of the youngest matching entry; 0 when no hit.
- write_retired  out  1  one-cycle pulse when the head entry is popped.
- count  out  CNT_W  valid entries.
- empty  out  1  count == 0.
- drained  out  1  empty and FSM in SB_IDLE; write-back uses it before syscall or serialising ops.

## Operation
- Circular FIFO: head and tail pointers plus `count`. A push writes the entry at tail when push_valid && push_ready.
- Drain FSM: SB_IDLE, SB_REQ, SB_WAIT.
  - SB_IDLE and count > 0 goes to SB_REQ. On that edge, load req/reqdata/reqtag from the head entry and set reqcyc.
  - SB_REQ and reqack goes to SB_WAIT, and reqcyc clears on that edge. If writeack is also high in the same cycle, pop immediately and go to SB_IDLE.
  - SB_WAIT and writeack: pop the head (advance head, decrement count), pulse write_retired, go to SB_IDLE.
  - writeack outside SB_REQ/SB_WAIT is ignored.
- req, reqdata and reqtag are registered and hold their value from SB_REQ entry until the next load. They are not cleared on pop.
- The head entry stays valid and forwardable until it is popped.
- Forwarding is combinational over the registered entries. It compares the full 64-bit address against every valid entry; the youngest match (closest to tail) wins. A push in the same cycle is not visible to lookup.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- When full, push_ready = 0 even if a pop occurs that cycle. There is no pass-through.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asserted low, async) values: reqcyc 0, req 0, reqdata 0, reqtag 0, count 0, empty 1, drained 1, push_ready 1, write_retired 0, lookup_hit 0, lookup_data 0, head = tail = 0, state SB_IDLE.
- Reset mid-transaction discards all entries and drops reqcyc immediately. The D-cache shares the same reset.
- Push accepted at the edge ending cycle N into an empty, idle buffer: reqcyc is high in cycle N+2.
- Pop happens at the edge where writeack is sampled. write_retired is high for exactly the following cycle.
- Back-to-back stores have a minimum one-cycle SB_IDLE bubble between writeack and the next reqcyc.
- push_ready, empty, count and drained are registered-state functions and have no combinational path from push_valid.

## Structure
- Package `store_buffer_pkg`:
  - `sb_state_t` enum.
  - REQ_WRITE = 1'b1 and REQ_MEMORY = 1'b1 tag constants.
  - `sb_entry_t` struct {addr[64], data[64], opcode[8]}.
- Sub-module `store_buffer_cam`: DEPTH-way address compare with youngest-match priority select. Its inputs are the entries, a valid mask and the head pointer. Its outputs are hit and data.
- FIFO storage, pointers and FSM live in the top module.

## Test plan
- Single store: push addr 0x1000, data 0xDEAD_BEEF, opcode 0x89. Expect reqcyc rising 2 cycles later, req = 0x1000 and reqtag = {1,1,0x89}. After reqack then writeack, expect write_retired to pulse once and drained = 1.
- Fill and wrap: DEPTH = 4, push 6 stores with the cache stalled. Expect push_ready = 0 after 4 pushes. Then release acks; expect all 6 issued in order, with addresses checked across the pointer wrap.
- Forwarding: push 0x2000/0x11 then 0x2000/0x22. Expect lookup_addr 0x2000 to give hit with data 0x22. Expect lookup 0x2008 to give no hit with data 0. After both are popped, expect no hit for 0x2000.
- Same-cycle reqack and writeack in SB_REQ: expect a single pop, count to drop by 1, and the FSM back in SB_IDLE.
- Push and pop in the same cycle with count = 2: expect count to stay 2 and the next request to carry the correct head entry.
- Async reset asserted while in SB_WAIT with 3 entries: expect reqcyc = 0, count = 0 and drained = 1 before the next clk edge. A later writeack must be ignored.
